// File: rtl/instr_encoder.sv
// RV32I field-level instruction encoder that writes packed words into instruction
// memory at an auto-incrementing address (IDLE -> ENC -> WR per request).
module instr_encoder #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op_class,
  input  logic [2:0]    funct3,
  input  logic          funct7b5,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [12:0]   imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err,
  output logic [1:0]    state_dbg
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // the requester may drop or change in_valid at any time before that.
  typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1, WR = 2'd2} state_t;

  state_t        state_q;
  logic [2:0]    op_q;
  logic [2:0]    f3_q;
  logic          f7_q;
  logic [4:0]    rd_q;
  logic [4:0]    rs1_q;
  logic [4:0]    rs2_q;
  logic [12:0]   imm_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   word_q;
  logic [AW:0]   count_q;
  logic          err_q;

  logic          accept;
  logic          legal;
  logic [31:0]   word_d;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign in_ready  = (state_q == IDLE) && !full && !clear;
  assign accept    = in_valid && in_ready;
  assign legal     = (op_q <= 3'd4);
  // clear must suppress a write already scheduled for this cycle
  assign mem_we    = we_q && !clear;
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign count     = count_q;
  assign err       = err_q;
  assign state_dbg = state_q;

  always_comb begin
    word_d = '0;
    case (op_q)
      3'd0: word_d = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0000011};
      3'd1: word_d = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], 7'b0100011};
      3'd2: word_d = {1'b0, f7_q, 5'b00000, rs2_q, rs1_q, f3_q, rd_q, 7'b0110011};
      3'd3: begin
        if (f3_q == 3'b001 || f3_q == 3'b101)
          word_d = {1'b0, f7_q, 5'b00000, imm_q[4:0], rs1_q, f3_q, rd_q, 7'b0010011};
        else
          word_d = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0010011};
      end
      3'd4: word_d = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                      imm_q[4:1], imm_q[11], 7'b1100011};
      default: word_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      f3_q    <= '0;
      f7_q    <= 1'b0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      word_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= op_class;
            f3_q    <= funct3;
            f7_q    <= funct7b5;
            rd_q    <= rd;
            rs1_q   <= rs1;
            rs2_q   <= rs2;
            imm_q   <= imm;
            state_q <= ENC;
          end
        end
        ENC: begin
          if (!legal) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            word_q  <= word_d;
            addr_q  <= count_q[AW-1:0];
            we_q    <= 1'b1;
            state_q <= WR;
          end
        end
        WR: begin
          we_q    <= 1'b0;
          count_q <= count_q + {{AW{1'b0}}, 1'b1};
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
